rv32i_test_sequencer: RTL and testbench
=======================================

// Module: rv32i_test_sequencer
// PURPOSE
//   Hardware sequencer for one directed test run on rv32i_core.
//   Per test: optionally zeroes regfile x1..x31 and memory, pulses core reset
//   and releases halt. It then watches for ecall (pass/fail from x3/gp) or a
//   cycle timeout, and finally re-halts the core and reports the result.
//   Sits between the bench/DII host and the core.
// PARAMETERS
//   MEM_WORDS      1024  memory depth in 32-bit words; MEM_WORDS >= 1
//   RST_CYCLES     10    core reset low time in RESET state, >= 1
//   TIMEOUT_CYCLES 5000  maximum RUN cycles before TIMEOUT, >= 1
//   CNT_W          16    cycle counter width; 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start_i      in   1      request test run; sampled only in IDLE
//   clear_i      in   1      with start_i: run clear phases first
//   abort_i      in   1      force return to IDLE from any state
//   is_ecall_i   in   1      core retiring ecall this cycle
//   gp_i         in   32     core regfile x3 value
//   core_rst_n_o out  1      reset to core, active-low
//   halt_o       out  1      halt to core/DII shim
//   rf_we_o      out  1      regfile write strobe (clear)
//   rf_addr_o    out  5      regfile write index
//   mem_we_o     out  1      memory write strobe (clear)
//   mem_addr_o   out  $clog2(MEM_WORDS)  memory word index
//   wdata_o      out  32     write data, constant 0
//   busy_o       out  1      high in every state except IDLE
//   done_o       out  1      one-cycle pulse when a run completes
//   result_o     out  2      00 none, 01 PASS, 10 FAIL, 11 TIMEOUT
//   cycles_o     out  CNT_W  RUN cycles of last/current run
// BEHAVIOUR
//   Reset values: core_rst_n_o=0, halt_o=1, all strobes 0, addrs 0,
//     busy_o=0, done_o=0, result_o=00, cycles_o=0; state IDLE.
//   States: IDLE, CLR_RF, CLR_MEM, RESET, RUN, DONE.
//   IDLE: halt_o=1, core_rst_n_o=0. On start_i=1 (accepted start):
//     result_o<=00, cycles_o<=0; next state is CLR_RF if clear_i, else RESET.
//     start_i in any other state is ignored (no queueing).
//   CLR_RF: rf_we_o=1, rf_addr_o = 1..31, one per cycle (x0 never written).
//     Exactly 31 cycles, then CLR_MEM.
//   CLR_MEM: mem_we_o=1, mem_addr_o = 0..MEM_WORDS-1, one per cycle.
//     Exactly MEM_WORDS cycles, then RESET.
//   Strobes and addresses are registered outputs; they return to 0 outside
//     the clear states.
//   RESET: halt_o=0, core_rst_n_o=0 for exactly RST_CYCLES cycles, then RUN.
//   RUN: core_rst_n_o=1, halt_o=0; cycles_o increments once per cycle.
//     - is_ecall_i=1: result_o<=(gp_i==32'd1)?PASS:FAIL, then DONE.
//     - Otherwise, when cycles_o reaches TIMEOUT_CYCLES: result_o<=TIMEOUT,
//       then DONE.
//     - ecall and timeout in the same cycle: ecall wins.
//     - is_ecall_i is ignored outside RUN, including during RESET.
//   DONE: exactly one cycle. done_o=1, halt_o=1, core_rst_n_o=0; then IDLE.
//     result_o and cycles_o hold until the next accepted start.
//   abort_i=1 in any non-IDLE state: next state IDLE, halt_o=1,
//     core_rst_n_o=0, strobes 0, no done_o pulse, result_o=00.
//     abort_i has priority over ecall and timeout.
//   Start-to-core-release latency: 1 + (clear_i ? 31+MEM_WORDS : 0)
//     + RST_CYCLES cycles.
//   rst_n low mid-run: all state and outputs go immediately (async) to their
//     reset values; the core stays held in reset and halt.
// TESTING
//   Start with clear_i=0; gp_i=1 and ecall on RUN cycle 20 -> done_o pulse,
//     result_o=01, cycles_o=20, halt_o=1.
//   gp_i=5 at ecall -> result_o=10; same flow otherwise.
//   No ecall, TIMEOUT_CYCLES=50 -> result_o=11 exactly 50 RUN cycles after
//     core_rst_n_o rises.
//   clear_i=1, MEM_WORDS=16 -> 31 rf writes to x1..x31, then 16 mem writes
//     to 0..15 with wdata 0, then 10 reset cycles.
//   Ecall on the timeout cycle -> PASS/FAIL, not TIMEOUT. start_i while busy
//     -> ignored.
//   abort_i in CLR_MEM, and rst_n low in RUN -> IDLE/reset values, no done_o
//     pulse; the next start runs normally.

Source files
------------

// File: rtl/rv32i_test_sequencer.sv
// rv32i_test_sequencer: drives one directed test run on rv32i_core.
// Optionally clears x1..x31 and data memory, holds the core in reset for a
// fixed time, lets it run until ecall or a cycle timeout, then re-halts it
// and reports PASS / FAIL / TIMEOUT together with the number of RUN cycles.
module rv32i_test_sequencer #(
  parameter int MEM_WORDS      = 1024,
  parameter int RST_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 16,
  localparam int AW            = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             abort_i,
  input  logic             is_ecall_i,
  input  logic [31:0]      gp_i,
  output logic             core_rst_n_o,
  output logic             halt_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_addr_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [31:0]      wdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       result_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam int RW = $clog2(RST_CYCLES + 1);

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_PASS    = 2'b01;
  localparam logic [1:0] RES_FAIL    = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE, CLR_RF, CLR_MEM, RESET, RUN, DONE
  } state_t;

  state_t            state_reg;
  logic [RW-1:0]     rst_cnt_reg;
  logic [CNT_W-1:0]  cycles_inc;

  // Clear phases only ever write zero.
  assign wdata_o    = 32'd0;
  assign cycles_inc = cycles_o + CNT_W'(1);

  // Sequencer FSM; every output is registered and set on the transition
  // into the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rst_cnt_reg  <= '0;
      core_rst_n_o <= 1'b0;
      halt_o       <= 1'b1;
      rf_we_o      <= 1'b0;
      rf_addr_o    <= '0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      result_o     <= RES_NONE;
      cycles_o     <= '0;
    end else begin
      done_o <= 1'b0;
      if (abort_i && state_reg != IDLE) begin
        // Abort beats ecall/timeout: park the core, no completion pulse.
        state_reg    <= IDLE;
        core_rst_n_o <= 1'b0;
        halt_o       <= 1'b1;
        rf_we_o      <= 1'b0;
        rf_addr_o    <= '0;
        mem_we_o     <= 1'b0;
        mem_addr_o   <= '0;
        busy_o       <= 1'b0;
        result_o     <= RES_NONE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_i) begin
              result_o <= RES_NONE;
              cycles_o <= '0;
              busy_o   <= 1'b1;
              if (clear_i) begin
                state_reg <= CLR_RF;
                rf_we_o   <= 1'b1;
                rf_addr_o <= 5'd1;   // x0 is hardwired, skip it
              end else begin
                state_reg   <= RESET;
                halt_o      <= 1'b0;
                rst_cnt_reg <= '0;
              end
            end
          end
          CLR_RF: begin
            if (rf_addr_o == 5'd31) begin
              state_reg  <= CLR_MEM;
              rf_we_o    <= 1'b0;
              rf_addr_o  <= '0;
              mem_we_o   <= 1'b1;
              mem_addr_o <= '0;
            end else begin
              rf_addr_o <= rf_addr_o + 5'd1;
            end
          end
          CLR_MEM: begin
            if (mem_addr_o == AW'(MEM_WORDS - 1)) begin
              state_reg   <= RESET;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= '0;
              halt_o      <= 1'b0;
              rst_cnt_reg <= '0;
            end else begin
              mem_addr_o <= mem_addr_o + AW'(1);
            end
          end
          RESET: begin
            if (rst_cnt_reg == RW'(RST_CYCLES - 1)) begin
              state_reg    <= RUN;
              core_rst_n_o <= 1'b1;
            end else begin
              rst_cnt_reg <= rst_cnt_reg + RW'(1);
            end
          end
          RUN: begin
            cycles_o <= cycles_inc;
            // Ecall takes precedence when it lands on the timeout cycle.
            if (is_ecall_i || cycles_inc == CNT_W'(TIMEOUT_CYCLES)) begin
              if (is_ecall_i) begin
                result_o <= (gp_i == 32'd1) ? RES_PASS : RES_FAIL;
              end else begin
                result_o <= RES_TIMEOUT;
              end
              state_reg    <= DONE;
              done_o       <= 1'b1;
              halt_o       <= 1'b1;
              core_rst_n_o <= 1'b0;
            end
          end
          DONE: begin
            state_reg <= IDLE;
            busy_o    <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32i_test_sequencer.sv
// Bench for rv32i_test_sequencer: table of directed runs plus hand-written
// abort and mid-run reset sequences; completions checked via a scoreboard.
module tb_rv32i_test_sequencer;

  localparam int MW  = 16;
  localparam int RC  = 10;
  localparam int TO  = 50;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          is_ecall_i = 1'b0;
  logic [31:0]   gp_i = 32'd0;
  logic          core_rst_n_o;
  logic          halt_o;
  logic          rf_we_o;
  logic [4:0]    rf_addr_o;
  logic          mem_we_o;
  logic [3:0]    mem_addr_o;
  logic [31:0]   wdata_o;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    result_o;
  logic [CW-1:0] cycles_o;

  rv32i_test_sequencer #(
    .MEM_WORDS(MW), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
    .abort_i(abort_i), .is_ecall_i(is_ecall_i), .gp_i(gp_i),
    .core_rst_n_o(core_rst_n_o), .halt_o(halt_o), .rf_we_o(rf_we_o),
    .rf_addr_o(rf_addr_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clear;
    int          ecall_n;        // RUN cycle carrying ecall, 0 = never
    logic [31:0] gp;
    logic        ecall_in_reset; // also assert ecall during RESET
    logic        start_busy;     // also pulse start_i during RUN
    logic [1:0]  exp_res;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [1:0]    res;
    logic [CW-1:0] cyc;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   rf_cnt = 0;
  int   mem_cnt = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Clear-write monitor and completion scoreboard.
  always @(negedge clk) begin
    if (start_i && !busy_o && rst_n) begin
      rf_cnt  = 0;
      mem_cnt = 0;
    end
    if (rf_we_o) begin
      chk("rf_addr", rf_addr_o, rf_cnt + 1);
      chk("rf_wdata", wdata_o, 0);
      rf_cnt++;
    end
    if (mem_we_o) begin
      chk("mem_addr", mem_addr_o, mem_cnt);
      chk("mem_wdata", wdata_o, 0);
      mem_cnt++;
    end
    if (done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", result_o, e.res);
        chk("sb_cycles", cycles_o, e.cyc);
        $display("done: result=%0d cycles=%0d", result_o, cycles_o);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int rel;
    int rcyc;
    int n;
    bit got;
    start_i = 1'b1;
    clear_i = v.clear;
    sb.push_back('{v.exp_res, CW'(v.exp_cyc)});
    @(posedge clk); #1;
    start_i = 1'b0;
    clear_i = 1'b0;
    rel  = 1;
    rcyc = 0;
    chk("start_result_cleared", result_o, 0);
    chk("start_cycles_cleared", cycles_o, 0);
    chk("busy_after_start", busy_o, 1);
    while (!core_rst_n_o && rel < 2000) begin
      if (!halt_o) begin
        rcyc++;
        if (v.ecall_in_reset) begin
          is_ecall_i = 1'b1;
          gp_i = 32'd0;
        end
      end
      @(posedge clk); #1;
      is_ecall_i = 1'b0;
      rel++;
    end
    chk("release_latency", rel, 1 + (v.clear ? 31 + MW : 0) + RC);
    chk("reset_cycles", rcyc, RC);
    chk("rf_writes", rf_cnt, v.clear ? 31 : 0);
    chk("mem_writes", mem_cnt, v.clear ? MW : 0);
    gp_i = v.gp;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      n++;
      is_ecall_i = (n == v.ecall_n);
      if (v.start_busy && n == 5) start_i = 1'b1;
      @(posedge clk); #1;
      is_ecall_i = 1'b0;
      start_i = 1'b0;
      got = done_o;
    end
    chk("run_length", n, v.exp_cyc);
    chk("halt_at_done", halt_o, 1);
    chk("core_rst_at_done", core_rst_n_o, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done_o, 0);
    chk("busy_idle", busy_o, 0);
    chk("result_hold", result_o, v.exp_res);
    repeat (3) @(posedge clk);
    #1;
    chk("cycles_hold", cycles_o, v.exp_cyc);
    $display("run: clear=%0d ecall_n=%0d gp=%0d -> result=%0d cycles=%0d",
             v.clear, v.ecall_n, v.gp, result_o, cycles_o);
  endtask

  task automatic check_idle_values(input string tag);
    chk({tag, "_core_rst"}, core_rst_n_o, 0);
    chk({tag, "_halt"}, halt_o, 1);
    chk({tag, "_rf_we"}, rf_we_o, 0);
    chk({tag, "_mem_we"}, mem_we_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_result"}, result_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0] = '{1'b0, 20, 32'd1, 1'b0, 1'b0, 2'd1, 20};
    vecs[1] = '{1'b0, 20, 32'd5, 1'b0, 1'b0, 2'd2, 20};
    vecs[2] = '{1'b0,  0, 32'd1, 1'b0, 1'b0, 2'd3, TO};
    vecs[3] = '{1'b1,  7, 32'd1, 1'b0, 1'b0, 2'd1, 7};
    vecs[4] = '{1'b0, TO, 32'd1, 1'b0, 1'b0, 2'd1, TO};
    vecs[5] = '{1'b0, TO, 32'd0, 1'b1, 1'b1, 2'd2, TO};
    vecs[6] = '{1'b0,  1, 32'd1, 1'b0, 1'b0, 2'd1, 1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_idle_values("reset");
    chk("reset_rf_addr", rf_addr_o, 0);
    chk("reset_mem_addr", mem_addr_o, 0);
    chk("reset_cycles", cycles_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort during memory clear
    start_i = 1'b1;
    clear_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    clear_i = 1'b0;
    w = 0;
    while (!(mem_we_o && mem_addr_o == 4'd5) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reach_clr_mem", mem_addr_o, 5);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check_idle_values("abort");
    repeat (5) @(posedge clk);
    #1;
    chk("abort_stays_idle", busy_o, 0);
    $display("abort in CLR_MEM: busy=%0d halt=%0d", busy_o, halt_o);
    run_vec(vecs[0]);

    // Asynchronous reset in RUN
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    w = 0;
    while (!core_rst_n_o && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rst_run_reached", core_rst_n_o, 1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_values("async_rst");
    chk("async_rst_cycles", cycles_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_busy", busy_o, 0);
    $display("rst_n in RUN: busy=%0d core_rst_n=%0d", busy_o, core_rst_n_o);
    run_vec(vecs[2]);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
